// File: rtl/mux_scan_capture.sv
// -----------------------------------------------------------------------------
// mux_scan_capture
//
// Sequential reader for a 6-to-1 single-bit mux. It walks the mux select
// through channels 0..5. On each channel it waits SETTLE_CYCLES cycles, then
// samples the mux output bit. The six samples are reassembled into the word
// that sits on the mux data inputs.
//
// Optional feature (compile-time macro MUX_SCAN_PROBE_EN):
//   Adds a PROBE pass after channel 5. The reader drives sel=6, which is out of
//   range for the mux, and checks that the mux returns 0. If it returns 1,
//   the sticky probe_err flag is set. Without the macro, probe_err is tied to 0
//   and sel stays within 0..5.
//
// Parameters
//   SETTLE_CYCLES  wait cycles between driving sel and sampling bit_in (0..15)
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   start       in   scan request, honoured only while idle
//   continuous  in   sampled at scan completion; 1 = begin next scan at once
//   bit_in      in   mux data_out[0]
//   sel         out  [2:0] mux select being driven
//   busy        out  high while a scan is in progress
//   word_out    out  [5:0] last completed word (bit i captured with sel=i)
//   word_valid  out  one-cycle pulse when word_out updates
//   probe_err   out  sticky: mux returned 1 for sel=6 (probe builds only)
// -----------------------------------------------------------------------------
module mux_scan_capture #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       continuous,
  input  logic       bit_in,
  output logic [2:0] sel,
  output logic       busy,
  output logic [5:0] word_out,
  output logic       word_valid,
  output logic       probe_err
);

  // The settle counter is 4 bits wide. Values above 15 wrap, so callers must
  // stay in range.
  localparam logic [3:0] SETTLE   = 4'(SETTLE_CYCLES);
  localparam logic [2:0] LAST_IDX = 3'd5;
`ifdef MUX_SCAN_PROBE_EN
  localparam logic [2:0] PROBE_SEL = 3'd6;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1
`ifdef MUX_SCAN_PROBE_EN
    ,
    PROBE = 2'd2
`endif
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [2:0] idx_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [5:0] shadow;
  logic [5:0] shadow_nxt;
  logic [2:0] sel_nxt;
  logic       busy_nxt;
  logic [5:0] word_nxt;
  logic       valid_nxt;
  logic       slot_done;
  logic       scan_done;
`ifdef MUX_SCAN_PROBE_EN
  logic       perr;
  logic       perr_nxt;
`endif

  // A sample slot ends on the edge where the settle count has been reached.
  // With SETTLE_CYCLES=0, every edge ends a slot.
  assign slot_done = (cnt == SETTLE);

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    sel_nxt    = sel;
    busy_nxt   = busy;
    word_nxt   = word_out;
    valid_nxt  = 1'b0;
    scan_done  = 1'b0;
`ifdef MUX_SCAN_PROBE_EN
    perr_nxt   = perr;
`endif

    case (state)
      IDLE: begin
        sel_nxt = 3'd0;
        if (start) begin
          state_nxt = SCAN;
          idx_nxt   = 3'd0;
          cnt_nxt   = 4'd0;
          busy_nxt  = 1'b1;
        end
      end

      SCAN: begin
        if (!slot_done) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          cnt_nxt = 4'd0;
          for (int i = 0; i < 6; i++) begin
            if (idx == 3'(i)) shadow_nxt[i] = bit_in;
          end
          if (idx != LAST_IDX) begin
            // The new select is presented on the same edge that closes the
            // previous slot. This keeps consecutive slots gap-free.
            idx_nxt = idx + 3'd1;
            sel_nxt = idx + 3'd1;
          end else begin
`ifdef MUX_SCAN_PROBE_EN
            state_nxt = PROBE;
            sel_nxt   = PROBE_SEL;
`else
            scan_done = 1'b1;
`endif
          end
        end
      end

`ifdef MUX_SCAN_PROBE_EN
      PROBE: begin
        if (!slot_done) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          cnt_nxt   = 4'd0;
          scan_done = 1'b1;
          // A correct mux returns 0 for an out-of-range select.
          if (bit_in) perr_nxt = 1'b1;
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        sel_nxt   = 3'd0;
      end
    endcase

    // Completion publishes the shadow, including the bit captured on this
    // same edge. A scan that is abandoned part-way never reaches word_out.
    if (scan_done) begin
      word_nxt  = shadow_nxt;
      valid_nxt = 1'b1;
      idx_nxt   = 3'd0;
      cnt_nxt   = 4'd0;
      sel_nxt   = 3'd0;
      if (continuous) begin
        state_nxt = SCAN;
        busy_nxt  = 1'b1;
      end else begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      cnt        <= 4'd0;
      shadow     <= 6'd0;
      sel        <= 3'd0;
      busy       <= 1'b0;
      word_out   <= 6'd0;
      word_valid <= 1'b0;
`ifdef MUX_SCAN_PROBE_EN
      perr       <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      shadow     <= shadow_nxt;
      sel        <= sel_nxt;
      busy       <= busy_nxt;
      word_out   <= word_nxt;
      word_valid <= valid_nxt;
`ifdef MUX_SCAN_PROBE_EN
      perr       <= perr_nxt;
`endif
    end
  end

`ifdef MUX_SCAN_PROBE_EN
  assign probe_err = perr;
`else
  assign probe_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_capture
//
// Two reader instances sit side by side, with SETTLE_CYCLES=0 and
// SETTLE_CYCLES=1. Each one reads a behavioural 6-to-1 mux model. The
// reference is timing arithmetic: slot length S+1, N slots per scan, and
// bit i sampled on edge (i+1)(S+1) of its scan. A per-edge history of the
// mux data is used when data changes while a scan is running.
// -----------------------------------------------------------------------------
module tb_mux_scan_capture;

`ifdef MUX_SCAN_PROBE_EN
  localparam int N = 7;
`else
  localparam int N = 6;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start      [2];
  logic       continuous [2];
  logic       bit_in     [2];
  logic       force6     [2];
  logic [5:0] data_in    [2];
  logic [2:0] sel        [2];
  logic       busy       [2];
  logic [5:0] word_out   [2];
  logic       word_valid [2];
  logic       probe_err  [2];

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_word [2];
  logic       exp_perr [2];

  // Behavioural mux: in-range select returns the data bit, sel=6 returns
  // the fault-injection value, and anything else returns 0.
  function automatic logic mux_model(input logic [2:0] s, input logic [5:0] d, input logic f);
    if (s < 3'd6) return d[s];
    else if (s == 3'd6) return f;
    else return 1'b0;
  endfunction

  assign bit_in[0] = mux_model(sel[0], data_in[0], force6[0]);
  assign bit_in[1] = mux_model(sel[1], data_in[1], force6[1]);

  mux_scan_capture #(.SETTLE_CYCLES(0)) u_dut_s0 (
    .clk        (clk),
    .reset      (reset),
    .start      (start[0]),
    .continuous (continuous[0]),
    .bit_in     (bit_in[0]),
    .sel        (sel[0]),
    .busy       (busy[0]),
    .word_out   (word_out[0]),
    .word_valid (word_valid[0]),
    .probe_err  (probe_err[0])
  );

  mux_scan_capture #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk        (clk),
    .reset      (reset),
    .start      (start[1]),
    .continuous (continuous[1]),
    .bit_in     (bit_in[1]),
    .sel        (sel[1]),
    .busy       (busy[1]),
    .word_out   (word_out[1]),
    .word_valid (word_valid[1]),
    .probe_err  (probe_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Select expected k cycles after the edge that started the scan.
  function automatic logic [2:0] exp_sel(input int k, input int s);
    return 3'(k / (s + 1));
  endfunction

  task automatic check_outs(input int d, input logic [2:0] esel, input logic ebusy,
                            input logic evalid, input logic [5:0] eword);
    check($sformatf("d%0d_sel", d),        32'(sel[d]),        32'(esel));
    check($sformatf("d%0d_busy", d),       32'(busy[d]),       32'(ebusy));
    check($sformatf("d%0d_word_valid", d), 32'(word_valid[d]), 32'(evalid));
    check($sformatf("d%0d_word_out", d),   32'(word_out[d]),   32'(eword));
    check($sformatf("d%0d_probe_err", d),  32'(probe_err[d]),  32'(exp_perr[d]));
  endtask

  // Call at a negedge while the DUT is idle or in its word_valid cycle.
  // Returns at the negedge after the completion edge, when word_valid is high.
  task automatic scan_once(input int d, input logic [5:0] w, input bit mid_start);
    int L;
    logic [5:0] prev;
    L    = N * (d + 1);
    prev = exp_word[d];
    data_in[d] = w;
    start[d]   = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    for (int k = 0; k < L; k++) begin
      check_outs(d, exp_sel(k, d), 1'b1, 1'b0, prev);
      start[d] = (mid_start && k == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    exp_word[d] = w;
    if (N == 7 && force6[d]) exp_perr[d] = 1'b1;
    check_outs(d, 3'd0, 1'b0, 1'b1, w);
  endtask

  task automatic settle_idle(input int d);
    @(negedge clk);
    check_outs(d, 3'd0, 1'b0, 1'b0, exp_word[d]);
  endtask

  // Run m back-to-back scans in continuous mode. The data changes before edge
  // change_at. Continuous is dropped during the last scan.
  task automatic cont_run(input int d, input int m, input logic [5:0] w0,
                          input logic [5:0] w1, input int change_at);
    int L;
    int T;
    int kk;
    int base;
    logic [5:0] hist [0:255];
    logic [5:0] expw;
    L = N * (d + 1);
    T = m * L;
    data_in[d]    = w0;
    continuous[d] = 1'b1;
    start[d]      = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check_outs(d, 3'd0, 1'b1, 1'b0, exp_word[d]);
    for (int t = 1; t <= T; t++) begin
      if (t == change_at) data_in[d] = w1;
      if (t == T - L + 1) continuous[d] = 1'b0;
      hist[t] = data_in[d];
      @(negedge clk);
      kk = t % L;
      if (kk == 0) begin
        base = t - L;
        for (int i = 0; i < 6; i++) expw[i] = hist[base + (i + 1) * (d + 1)][i];
        exp_word[d] = expw;
        check_outs(d, 3'd0, (t != T), 1'b1, expw);
        if (t == T && change_at <= T - L + 1)
          check($sformatf("d%0d_cont_new_word", d), 32'(word_out[d]), 32'(w1));
      end else begin
        check_outs(d, exp_sel(kk, d), 1'b1, 1'b0, exp_word[d]);
      end
    end
  endtask

  initial begin
    int d;
    logic [5:0] w;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; continuous[i] = 1'b0; force6[i] = 1'b0;
      data_in[i] = 6'd0; exp_word[i] = 6'd0; exp_perr[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_outs(0, 3'd0, 1'b0, 1'b0, 6'd0);
    check_outs(1, 3'd0, 1'b0, 1'b0, 6'd0);
    reset = 1'b0;
    settle_idle(0);
    settle_idle(1);

    // Single scan, settle 1.
    scan_once(1, 6'b101101, 1'b0);
    settle_idle(1);

    // Continuous, settle 0, data changes during the second scan.
    cont_run(0, 4, 6'b010011, 6'b111000, N + 3);
    settle_idle(0);

    // Start while busy is ignored; then start in the word_valid cycle chains.
    scan_once(1, 6'b011010, 1'b1);
    scan_once(1, 6'b100101, 1'b0);
    settle_idle(1);

    // Reset partway through a scan, at idx=3.
    data_in[1] = 6'b110110;
    start[1]   = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (6) @(negedge clk);
    check("d1_sel_before_reset", 32'(sel[1]), 32'd3);
    reset = 1'b1;
    exp_word[0] = 6'd0; exp_word[1] = 6'd0;
    exp_perr[0] = 1'b0; exp_perr[1] = 1'b0;
    @(negedge clk);
    check_outs(1, 3'd0, 1'b0, 1'b0, 6'd0);
    reset = 1'b0;
    settle_idle(1);

    // Probe: faulty mux at sel=6, the flag is sticky across scans, and reset clears it.
    force6[1] = 1'b1;
    scan_once(1, 6'b001111, 1'b0);
    settle_idle(1);
    force6[1] = 1'b0;
    scan_once(1, 6'b110000, 1'b0);
    settle_idle(1);
    reset = 1'b1;
    exp_word[0] = 6'd0; exp_word[1] = 6'd0;
    exp_perr[0] = 1'b0; exp_perr[1] = 1'b0;
    @(negedge clk);
    check_outs(1, 3'd0, 1'b0, 1'b0, 6'd0);
    reset = 1'b0;
    settle_idle(1);

    // Randomized scans, with chained starts and ignored mid-scan starts.
    repeat (10) begin
      d = int'($urandom_range(0, 1));
      force6[d] = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) begin
        w = 6'($urandom);
        scan_once(d, w, 1'($urandom_range(0, 1)));
      end
      settle_idle(d);
      force6[d] = 1'b0;
    end

    // Randomized continuous run on the settle-1 reader.
    cont_run(1, 3, 6'($urandom), 6'($urandom), int'($urandom_range(1, 2 * N * 2)));
    settle_idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
